// File: rtl/mac_learning_table.sv
// MAC learning/forwarding table: sequential scan per lookup, learn on result,
// with station moves, oldest-entry replacement, aging and flush.
module mac_learning_table #(
  parameter int unsigned NUMBER_OF_PORTS = 2,
  parameter int unsigned TABLE_ENTRIES   = 16,
  parameter int unsigned AGE_WIDTH       = 8,
  parameter int unsigned AGE_LIMIT       = 200,
  localparam int unsigned PORT_INDEX_WIDTH = $clog2(NUMBER_OF_PORTS),
  localparam int unsigned COUNT_WIDTH      = $clog2(TABLE_ENTRIES) + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [47:0]                 lookup_destination_mac,
  input  logic [47:0]                 lookup_source_mac,
  input  logic [PORT_INDEX_WIDTH-1:0] lookup_source_port,
  output logic                        result_valid,
  output logic [NUMBER_OF_PORTS-1:0]  result_port_mask,
  output logic                        result_hit,
  input  logic                        age_tick,
  input  logic                        flush,
  output logic [COUNT_WIDTH-1:0]      entry_count
);

  localparam int unsigned IDX_WIDTH  = $clog2(TABLE_ENTRIES);
  localparam int unsigned MAC_WIDTH  = 48;
  localparam int unsigned GROUP_BIT  = 40;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_RESULT = 3'd2;
  localparam logic [2:0] ST_AGE    = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;

  logic [2:0] state_q, state_d;

  logic [TABLE_ENTRIES-1:0] valid_q, valid_d;
  logic [MAC_WIDTH-1:0]        mac_q  [TABLE_ENTRIES];
  logic [MAC_WIDTH-1:0]        mac_d  [TABLE_ENTRIES];
  logic [PORT_INDEX_WIDTH-1:0] port_q [TABLE_ENTRIES];
  logic [PORT_INDEX_WIDTH-1:0] port_d [TABLE_ENTRIES];
  logic [AGE_WIDTH-1:0]        age_q  [TABLE_ENTRIES];
  logic [AGE_WIDTH-1:0]        age_d  [TABLE_ENTRIES];

  logic flush_pending_q, flush_pending_d;
  logic age_pending_q, age_pending_d;

  logic [MAC_WIDTH-1:0]        req_dst_q, req_dst_d;
  logic [MAC_WIDTH-1:0]        req_src_q, req_src_d;
  logic [PORT_INDEX_WIDTH-1:0] req_port_q, req_port_d;
  logic [IDX_WIDTH-1:0]        scan_idx_q, scan_idx_d;

  // Scan trackers
  logic                        dst_hit_q, dst_hit_d, dst_hit_n;
  logic [PORT_INDEX_WIDTH-1:0] dst_port_q, dst_port_d, dst_port_n;
  logic                        src_hit_q, src_hit_d, src_hit_n;
  logic [IDX_WIDTH-1:0]        src_idx_q, src_idx_d, src_idx_n;
  logic                        free_found_q, free_found_d, free_found_n;
  logic [IDX_WIDTH-1:0]        free_idx_q, free_idx_d, free_idx_n;
  logic                        old_found_q, old_found_d, old_found_n;
  logic [IDX_WIDTH-1:0]        old_idx_q, old_idx_d, old_idx_n;
  logic [AGE_WIDTH-1:0]        old_age_q, old_age_d, old_age_n;

  logic                        result_valid_q, result_valid_d;
  logic                        result_hit_q, result_hit_d;
  logic [NUMBER_OF_PORTS-1:0]  result_mask_q, result_mask_d;
  logic                        lookup_ready_q, lookup_ready_d;
  logic [COUNT_WIDTH-1:0]      entry_count_q, entry_count_d;

  logic                        cur_valid;
  logic [MAC_WIDTH-1:0]        cur_mac;
  logic [PORT_INDEX_WIDTH-1:0] cur_port;
  logic [AGE_WIDTH-1:0]        cur_age;
  logic                        flush_clr, age_clr;
  logic [IDX_WIDTH-1:0]        learn_idx;
  logic [AGE_WIDTH-1:0]        aged;

  function automatic logic [NUMBER_OF_PORTS-1:0] flood_mask(input logic [PORT_INDEX_WIDTH-1:0] src);
    logic [NUMBER_OF_PORTS-1:0] m;
    for (int p = 0; p < int'(NUMBER_OF_PORTS); p++) m[p] = (PORT_INDEX_WIDTH'(p) != src);
    return m;
  endfunction

  function automatic logic [NUMBER_OF_PORTS-1:0] one_hot(input logic [PORT_INDEX_WIDTH-1:0] idx);
    logic [NUMBER_OF_PORTS-1:0] m;
    for (int p = 0; p < int'(NUMBER_OF_PORTS); p++) m[p] = (PORT_INDEX_WIDTH'(p) == idx);
    return m;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [TABLE_ENTRIES-1:0] v);
    logic [COUNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < int'(TABLE_ENTRIES); i++) c = c + COUNT_WIDTH'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    mac_d          = mac_q;
    port_d         = port_q;
    age_d          = age_q;
    req_dst_d      = req_dst_q;
    req_src_d      = req_src_q;
    req_port_d     = req_port_q;
    scan_idx_d     = scan_idx_q;
    dst_hit_d      = dst_hit_q;
    dst_port_d     = dst_port_q;
    src_hit_d      = src_hit_q;
    src_idx_d      = src_idx_q;
    free_found_d   = free_found_q;
    free_idx_d     = free_idx_q;
    old_found_d    = old_found_q;
    old_idx_d      = old_idx_q;
    old_age_d      = old_age_q;
    result_valid_d = 1'b0;
    result_hit_d   = result_hit_q;
    result_mask_d  = result_mask_q;
    flush_clr      = 1'b0;
    age_clr        = 1'b0;
    learn_idx      = '0;
    aged           = '0;

    // Fold the entry under the scan pointer into the running trackers
    cur_valid    = valid_q[scan_idx_q];
    cur_mac      = mac_q[scan_idx_q];
    cur_port     = port_q[scan_idx_q];
    cur_age      = age_q[scan_idx_q];
    dst_hit_n    = dst_hit_q;
    dst_port_n   = dst_port_q;
    src_hit_n    = src_hit_q;
    src_idx_n    = src_idx_q;
    free_found_n = free_found_q;
    free_idx_n   = free_idx_q;
    old_found_n  = old_found_q;
    old_idx_n    = old_idx_q;
    old_age_n    = old_age_q;
    if (cur_valid && cur_mac == req_dst_q) begin
      dst_hit_n  = 1'b1;
      dst_port_n = cur_port;
    end
    if (cur_valid && cur_mac == req_src_q) begin
      src_hit_n = 1'b1;
      src_idx_n = scan_idx_q;
    end
    if (!cur_valid && !free_found_q) begin
      free_found_n = 1'b1;
      free_idx_n   = scan_idx_q;
    end
    if (cur_valid && (!old_found_q || cur_age > old_age_q)) begin
      old_found_n = 1'b1;
      old_idx_n   = scan_idx_q;
      old_age_n   = cur_age;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_pending_q) begin
          state_d = ST_FLUSH;
        end else if (age_pending_q) begin
          state_d = ST_AGE;
        end else if (lookup_valid && lookup_ready_q) begin
          state_d      = ST_SCAN;
          req_dst_d    = lookup_destination_mac;
          req_src_d    = lookup_source_mac;
          req_port_d   = lookup_source_port;
          scan_idx_d   = '0;
          dst_hit_d    = 1'b0;
          dst_port_d   = '0;
          src_hit_d    = 1'b0;
          src_idx_d    = '0;
          free_found_d = 1'b0;
          free_idx_d   = '0;
          old_found_d  = 1'b0;
          old_idx_d    = '0;
          old_age_d    = '0;
        end
      end
      ST_SCAN: begin
        dst_hit_d    = dst_hit_n;
        dst_port_d   = dst_port_n;
        src_hit_d    = src_hit_n;
        src_idx_d    = src_idx_n;
        free_found_d = free_found_n;
        free_idx_d   = free_idx_n;
        old_found_d  = old_found_n;
        old_idx_d    = old_idx_n;
        old_age_d    = old_age_n;
        scan_idx_d   = scan_idx_q + IDX_WIDTH'(1);
        // Result registers load on the last compare so the strobe lines up with RESULT
        if (scan_idx_q == IDX_WIDTH'(TABLE_ENTRIES - 1)) begin
          state_d        = ST_RESULT;
          result_valid_d = 1'b1;
          result_hit_d   = dst_hit_n;
          if (req_dst_q[GROUP_BIT] || !dst_hit_n) begin
            result_mask_d = flood_mask(req_port_q);
          end else if (dst_port_n != req_port_q) begin
            result_mask_d = one_hot(dst_port_n);
          end else begin
            result_mask_d = '0;
          end
        end
      end
      ST_RESULT: begin
        if (src_hit_q)       learn_idx = src_idx_q;
        else if (free_found_q) learn_idx = free_idx_q;
        else                 learn_idx = old_idx_q;
        if (!req_src_q[GROUP_BIT]) begin
          valid_d[learn_idx] = 1'b1;
          mac_d[learn_idx]   = req_src_q;
          port_d[learn_idx]  = req_port_q;
          age_d[learn_idx]   = '0;
        end
        // Dispatch deferred maintenance directly so it does not cost an extra IDLE cycle
        if (flush_pending_q)    state_d = ST_FLUSH;
        else if (age_pending_q) state_d = ST_AGE;
        else                    state_d = ST_IDLE;
      end
      ST_AGE: begin
        for (int i = 0; i < int'(TABLE_ENTRIES); i++) begin
          aged = age_q[i] + AGE_WIDTH'(1);
          if (valid_q[i]) begin
            age_d[i] = aged;
            if (aged == AGE_WIDTH'(AGE_LIMIT)) valid_d[i] = 1'b0;
          end
        end
        age_clr = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        valid_d   = '0;
        flush_clr = 1'b1;
        age_clr   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    flush_pending_d = (flush_pending_q && !flush_clr) || flush;
    age_pending_d   = (age_pending_q && !age_clr) || age_tick;
    lookup_ready_d  = (state_d == ST_IDLE) && !flush_pending_d && !age_pending_d;
    entry_count_d   = popcount(valid_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      valid_q         <= '0;
      for (int i = 0; i < int'(TABLE_ENTRIES); i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
        age_q[i]  <= '0;
      end
      flush_pending_q <= 1'b0;
      age_pending_q   <= 1'b0;
      req_dst_q       <= '0;
      req_src_q       <= '0;
      req_port_q      <= '0;
      scan_idx_q      <= '0;
      dst_hit_q       <= 1'b0;
      dst_port_q      <= '0;
      src_hit_q       <= 1'b0;
      src_idx_q       <= '0;
      free_found_q    <= 1'b0;
      free_idx_q      <= '0;
      old_found_q     <= 1'b0;
      old_idx_q       <= '0;
      old_age_q       <= '0;
      result_valid_q  <= 1'b0;
      result_hit_q    <= 1'b0;
      result_mask_q   <= '0;
      lookup_ready_q  <= 1'b1;
      entry_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      mac_q           <= mac_d;
      port_q          <= port_d;
      age_q           <= age_d;
      flush_pending_q <= flush_pending_d;
      age_pending_q   <= age_pending_d;
      req_dst_q       <= req_dst_d;
      req_src_q       <= req_src_d;
      req_port_q      <= req_port_d;
      scan_idx_q      <= scan_idx_d;
      dst_hit_q       <= dst_hit_d;
      dst_port_q      <= dst_port_d;
      src_hit_q       <= src_hit_d;
      src_idx_q       <= src_idx_d;
      free_found_q    <= free_found_d;
      free_idx_q      <= free_idx_d;
      old_found_q     <= old_found_d;
      old_idx_q       <= old_idx_d;
      old_age_q       <= old_age_d;
      result_valid_q  <= result_valid_d;
      result_hit_q    <= result_hit_d;
      result_mask_q   <= result_mask_d;
      lookup_ready_q  <= lookup_ready_d;
      entry_count_q   <= entry_count_d;
    end
  end

  assign lookup_ready     = lookup_ready_q;
  assign result_valid     = result_valid_q;
  assign result_hit       = result_hit_q;
  assign result_port_mask = result_mask_q;
  assign entry_count      = entry_count_q;

endmodule
